// File: rtl/abft_pkg.sv
// ---------------------------------------------------------------------------
// abft_pkg
// Shared definitions for the ABFT checksum encoder slice:
//   - state_t     : encoder FSM states
//   - N/DW/CW     : default matrix dimension, element width, checksum width
//   - OUT_SEL_*   : meaning of the out_sel bit on the checksum port
// No ports (package).
// ---------------------------------------------------------------------------
package abft_pkg;

  localparam int N_DEFAULT  = 4;
  localparam int DW_DEFAULT = 8;
  localparam int CW_DEFAULT = 8;

  localparam logic OUT_SEL_COL = 1'b0;  // column checksum of A
  localparam logic OUT_SEL_ROW = 1'b1;  // row checksum of B

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    EMIT   = 3'd3,
    DONE   = 3'd4
  } state_t;

endpackage

// File: rtl/abft_checksum_encoder_if.sv
// ---------------------------------------------------------------------------
// abft_checksum_encoder_if
// Element input stream and checksum output stream of the encoder.
//   in_valid/in_ready/in_data             : row-major elements, A then B
//   out_valid/out_ready/out_data          : checksum stream
//   out_sel (0 = column of A, 1 = row of B), out_idx (column/row index)
// Modports: master = producer of elements / consumer of checksums,
//           slave  = the encoder.
// ---------------------------------------------------------------------------
interface abft_checksum_encoder_if #(
  parameter int N  = 4,
  parameter int DW = 8,
  parameter int CW = 8
);
  localparam int IW = $clog2(N);

  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_data;
  logic          out_sel;
  logic [IW-1:0] out_idx;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sel, out_idx
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sel, out_idx
  );

endinterface

// File: rtl/abft_cs_acc.sv
// ---------------------------------------------------------------------------
// abft_cs_acc
// Bank of N independent modular accumulators, CW bits each. Overflow wraps
// silently (mod 2^CW).
// Ports:
//   clk       in   clock, rising edge
//   rst       in   asynchronous active-low reset, clears all lanes
//   i_clear   in   synchronous clear of all lanes (takes priority over add)
//   i_add_en  in   add i_din into lane i_lane this cycle
//   i_lane    in   lane select
//   i_din     in   addend, zero-extended to CW
//   o_acc     out  flat bus, lane k at [k*CW +: CW]
// ---------------------------------------------------------------------------
module abft_cs_acc
  import abft_pkg::*;
#(
  parameter int N  = N_DEFAULT,
  parameter int DW = DW_DEFAULT,
  parameter int CW = CW_DEFAULT,
  localparam int LW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_clear,
  input  logic            i_add_en,
  input  logic [LW-1:0]   i_lane,
  input  logic [DW-1:0]   i_din,
  output logic [N*CW-1:0] o_acc
);

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_lane
      logic [CW-1:0] r_acc;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_acc <= '0;
        end else if (i_clear) begin
          r_acc <= '0;
        end else if (i_add_en && (i_lane == LW'(gi))) begin
          r_acc <= r_acc + CW'(i_din);
        end
      end

      assign o_acc[gi*CW +: CW] = r_acc;
    end
  endgenerate

endmodule

// File: rtl/abft_checksum_encoder.sv
// ---------------------------------------------------------------------------
// abft_checksum_encoder
// Streams in an NxN matrix A then an NxN matrix B (row-major), accumulates
// column checksums of A and row checksums of B mod 2^CW, then emits them as
// c0..c{N-1}, r0..r{N-1} over a valid/ready port.
// Ports:
//   clk    in   clock, rising edge
//   rst    in   asynchronous active-low reset
//   start  in   begin a run (only honoured in IDLE)
//   bus    slave modport: in_valid/in_ready/in_data element stream,
//          out_valid/out_ready/out_data/out_sel/out_idx checksum stream
//   busy   out  high in every state except IDLE
//   done   out  one-cycle pulse after the last checksum is accepted
// All outputs decode from registers only; nothing on the input side or
// out_ready reaches an output combinationally.
// ---------------------------------------------------------------------------
module abft_checksum_encoder
  import abft_pkg::*;
#(
  parameter int N  = N_DEFAULT,
  parameter int DW = DW_DEFAULT,
  parameter int CW = CW_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  abft_checksum_encoder_if.slave bus,
  output logic                   busy,
  output logic                   done
);

  localparam int LW   = $clog2(N);
  localparam int EC_W = 2 * LW + 1;   // log2(N*N)+1
  localparam int EM_W = LW + 1;       // counts 0..2N-1
  localparam logic [EC_W-1:0] LAST_ELEM = EC_W'(N * N - 1);
  localparam logic [EM_W-1:0] LAST_EMIT = EM_W'(2 * N - 1);

  state_t          r_state;
  state_t          w_state_next;
  logic [EC_W-1:0] r_elem_cnt;
  logic [EM_W-1:0] r_emit_cnt;

  logic            w_in_fire;
  logic            w_out_fire;
  logic            w_last_elem;
  logic            w_last_emit;
  logic            w_clear;
  logic [N*CW-1:0] w_col_bus;
  logic [N*CW-1:0] w_row_bus;
  logic            w_emit_row;
  logic [LW-1:0]   w_emit_idx;
  logic [CW-1:0]   w_col_sel;
  logic [CW-1:0]   w_row_sel;

  assign w_in_fire   = bus.in_valid && bus.in_ready;
  assign w_out_fire  = bus.out_valid && bus.out_ready;
  assign w_last_elem = (r_elem_cnt == LAST_ELEM);
  assign w_last_emit = (r_emit_cnt == LAST_EMIT);

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_clear      = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_next = LOAD_A;
          w_clear      = 1'b1;
        end
      end
      LOAD_A: if (w_in_fire && w_last_elem) w_state_next = LOAD_B;
      LOAD_B: if (w_in_fire && w_last_elem) w_state_next = EMIT;
      EMIT:   if (w_out_fire && w_last_emit) w_state_next = DONE;
      DONE:   w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // ---------------- counters ----------------
  // The element counter wraps to 0 after the last element of each matrix,
  // so LOAD_B starts at element 0 without needing a separate clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_elem_cnt <= '0;
      r_emit_cnt <= '0;
    end else begin
      if (w_clear) begin
        r_elem_cnt <= '0;
      end else if (w_in_fire) begin
        r_elem_cnt <= w_last_elem ? '0 : r_elem_cnt + EC_W'(1);
      end

      if (w_clear) begin
        r_emit_cnt <= '0;
      end else if (w_out_fire) begin
        r_emit_cnt <= w_last_emit ? '0 : r_emit_cnt + EM_W'(1);
      end
    end
  end

  // ---------------- accumulators ----------------
  // Column of A = element index mod N (low bits); row of B = index div N.
  abft_cs_acc #(.N(N), .DW(DW), .CW(CW)) u_col_acc (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_clear),
    .i_add_en (w_in_fire && (r_state == LOAD_A)),
    .i_lane   (r_elem_cnt[LW-1:0]),
    .i_din    (bus.in_data),
    .o_acc    (w_col_bus)
  );

  abft_cs_acc #(.N(N), .DW(DW), .CW(CW)) u_row_acc (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_clear),
    .i_add_en (w_in_fire && (r_state == LOAD_B)),
    .i_lane   (r_elem_cnt[2*LW-1:LW]),
    .i_din    (bus.in_data),
    .o_acc    (w_row_bus)
  );

  // ---------------- output mux ----------------
  // The emit counter's MSB separates the column phase from the row phase.
  assign w_emit_row = r_emit_cnt[LW];
  assign w_emit_idx = r_emit_cnt[LW-1:0];
  assign w_col_sel  = w_col_bus[w_emit_idx*CW +: CW];
  assign w_row_sel  = w_row_bus[w_emit_idx*CW +: CW];

  assign bus.in_ready  = (r_state == LOAD_A) || (r_state == LOAD_B);
  assign bus.out_valid = (r_state == EMIT);
  // Gate the payload so it reads 0 outside EMIT.
  assign bus.out_sel   = bus.out_valid ? (w_emit_row ? OUT_SEL_ROW : OUT_SEL_COL) : 1'b0;
  assign bus.out_idx   = bus.out_valid ? w_emit_idx : '0;
  assign bus.out_data  = bus.out_valid ? (w_emit_row ? w_row_sel : w_col_sel) : '0;

  assign busy = (r_state != IDLE);
  assign done = (r_state == DONE);

endmodule

// File: tb/tb_abft_checksum_encoder.sv
// ---------------------------------------------------------------------------
// tb_abft_checksum_encoder
// Scoreboard bench: expected checksums are computed from the matrices when
// they are driven, queued, and popped as the encoder emits them. Inputs and
// samples both happen on the falling edge.
// ---------------------------------------------------------------------------
module tb_abft_checksum_encoder;
  import abft_pkg::*;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int CW = 8;
  localparam int NN = N * N;
  localparam int IW = $clog2(N);

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic busy;
  logic done;

  abft_checksum_encoder_if #(.N(N), .DW(DW), .CW(CW)) bus ();

  abft_checksum_encoder #(.N(N), .DW(DW), .CW(CW)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bus   (bus),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          sel;
    logic [IW-1:0] idx;
    logic [CW-1:0] data;
  } item_t;

  item_t         exp_q[$];
  logic [DW-1:0] mat_a[NN];
  logic [DW-1:0] mat_b[NN];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int acc_cnt = 0;
  int done_cnt = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.in_valid && bus.in_ready) acc_cnt <= acc_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, required finish within time limit");
    $fatal(1);
  end

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic push_expected();
    logic [CW-1:0] s;
    item_t it;
    for (int j = 0; j < N; j++) begin
      s = '0;
      for (int i = 0; i < N; i++) s = s + CW'(mat_a[i*N+j]);
      it.sel = 1'b0; it.idx = IW'(j); it.data = s;
      exp_q.push_back(it);
    end
    for (int i = 0; i < N; i++) begin
      s = '0;
      for (int j = 0; j < N; j++) s = s + CW'(mat_b[i*N+j]);
      it.sel = 1'b1; it.idx = IW'(i); it.data = s;
      exp_q.push_back(it);
    end
  endtask

  task automatic fill_test1();
    for (int k = 0; k < NN; k++) begin
      mat_a[k] = 8'd1;
      mat_b[k] = DW'(k / N + 1);
    end
  endtask

  // Called and returns on a falling edge.
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Drives 'count' elements (A then B); start is raised while element
  // index == start_at. Returns on the falling edge after the last accept.
  task automatic feed(input int count, input bit gaps, input int start_at, output bit ok);
    int  k = 0;
    int  guard = 0;
    bit  tog = 1'b1;
    bit  acc_now;
    ok = 1'b1;
    while (k < count) begin
      bus.in_valid = gaps ? tog : 1'b1;
      tog = ~tog;
      bus.in_data = (k < NN) ? mat_a[k] : mat_b[(k - NN) % NN];
      start = (k == start_at);
      acc_now = bus.in_valid && bus.in_ready;
      @(negedge clk);
      if (acc_now) k++;
      guard++;
      if (guard > 500) begin
        ok = 1'b0;
        break;
      end
    end
    bus.in_valid = 1'b0;
    start = 1'b0;
  endtask

  // Waits for out_valid, records the payload; out_ready must already be 1.
  task automatic get_out(output item_t got, output bit ok);
    int guard = 0;
    ok = 1'b1;
    got = '0;
    while (!bus.out_valid) begin
      @(negedge clk);
      guard++;
      if (guard > 200) begin
        ok = 1'b0;
        return;
      end
    end
    got.sel = bus.out_sel; got.idx = bus.out_idx; got.data = bus.out_data;
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #12;
    n_vec++;
    if ({bus.in_ready, bus.out_valid, bus.out_sel, bus.out_idx, bus.out_data, busy, done} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got in_ready=%b out_valid=%b sel=%b idx=%0d data=%h busy=%b done=%b, required all 0",
               bus.in_ready, bus.out_valid, bus.out_sel, bus.out_idx, bus.out_data, busy, done);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b0 || bus.in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release_idle: got busy=%b in_ready=%b, required 0 0", busy, bus.in_ready);
    end
  endtask

  task automatic test_basic();
    item_t got, want;
    bit ok;
    int t0, d0;
    fill_test1();
    push_expected();
    d0 = done_cnt;
    t0 = cyc;
    pulse_start();
    feed(2*NN, 1'b0, -1, ok);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL t1_feed: got timeout, required %0d accepts", 2*NN); end
    for (int e = 0; e < 2*N; e++) begin
      get_out(got, ok);
      n_vec++;
      if (!ok || exp_q.size() == 0) begin
        n_err++; $display("FAIL t1_out[%0d]: got no checksum (timeout=%0d), required one", e, !ok);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          n_err++;
          $display("FAIL t1_out[%0d]: got sel=%0d idx=%0d data=%h, required sel=%0d idx=%0d data=%h",
                   e, got.sel, got.idx, got.data, want.sel, want.idx, want.data);
        end
      end
    end
    n_vec++;
    if (done !== 1'b1 || busy !== 1'b1) begin
      n_err++; $display("FAIL t1_done_state: got done=%b busy=%b, required 1 1", done, busy);
    end
    @(negedge clk);
    n_vec++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL t1_idle_after: got done=%b busy=%b, required 0 0", done, busy);
    end
    n_vec++;
    if (cyc - t0 != 2*N*N + 2*N + 2) begin
      n_err++; $display("FAIL t1_run_length: got %0d cycles, required %0d", cyc - t0, 2*N*N + 2*N + 2);
    end
    n_vec++;
    if (done_cnt - d0 != 1) begin
      n_err++; $display("FAIL t1_done_pulses: got %0d, required 1", done_cnt - d0);
    end
  endtask

  task automatic test_wrap();
    item_t got, want;
    bit ok;
    for (int k = 0; k < NN; k++) begin
      mat_a[k] = 8'hFF;
      mat_b[k] = 8'h80;
    end
    push_expected();
    pulse_start();
    feed(2*NN, 1'b0, -1, ok);
    for (int e = 0; e < 2*N; e++) begin
      get_out(got, ok);
      n_vec++;
      if (!ok || exp_q.size() == 0) begin
        n_err++; $display("FAIL t2_out[%0d]: got no checksum (timeout=%0d), required one", e, !ok);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          n_err++;
          $display("FAIL t2_out[%0d]: got sel=%0d idx=%0d data=%h, required sel=%0d idx=%0d data=%h",
                   e, got.sel, got.idx, got.data, want.sel, want.idx, want.data);
        end
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_backpressure();
    item_t got, want;
    bit ok;
    for (int k = 0; k < NN; k++) begin
      mat_a[k] = DW'(k * 7 + 3);
      mat_b[k] = DW'(k * 13 + 1);
    end
    push_expected();
    pulse_start();
    feed(2*NN, 1'b0, -1, ok);
    for (int e = 0; e < 2*N; e++) begin
      if (e == 2) begin
        // e=2 is on the port now; hold it for three cycles.
        bus.out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          @(negedge clk);
          n_vec++;
          if (exp_q.size() == 0 || bus.out_valid !== 1'b1 || bus.out_sel !== exp_q[0].sel ||
              bus.out_idx !== exp_q[0].idx || bus.out_data !== exp_q[0].data) begin
            n_err++;
            $display("FAIL t3_stall[%0d]: got valid=%b sel=%0d idx=%0d data=%h, required valid=1 idx=2 data held",
                     s, bus.out_valid, bus.out_sel, bus.out_idx, bus.out_data);
          end
        end
        bus.out_ready = 1'b1;
      end
      get_out(got, ok);
      n_vec++;
      if (!ok || exp_q.size() == 0) begin
        n_err++; $display("FAIL t3_out[%0d]: got no checksum (timeout=%0d), required one", e, !ok);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          n_err++;
          $display("FAIL t3_out[%0d]: got sel=%0d idx=%0d data=%h, required sel=%0d idx=%0d data=%h",
                   e, got.sel, got.idx, got.data, want.sel, want.idx, want.data);
        end
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_gaps();
    item_t got, want;
    bit ok;
    int a0;
    fill_test1();
    push_expected();
    a0 = acc_cnt;
    pulse_start();
    feed(2*NN, 1'b1, -1, ok);
    // Keep offering data during EMIT: nothing more may be accepted.
    bus.in_valid = 1'b1;
    for (int e = 0; e < 2*N; e++) begin
      get_out(got, ok);
      n_vec++;
      if (!ok || exp_q.size() == 0) begin
        n_err++; $display("FAIL t4_out[%0d]: got no checksum (timeout=%0d), required one", e, !ok);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          n_err++;
          $display("FAIL t4_out[%0d]: got sel=%0d idx=%0d data=%h, required sel=%0d idx=%0d data=%h",
                   e, got.sel, got.idx, got.data, want.sel, want.idx, want.data);
        end
      end
    end
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++;
    if (acc_cnt - a0 != 2*NN) begin
      n_err++; $display("FAIL t4_accept_count: got %0d, required %0d", acc_cnt - a0, 2*NN);
    end
  endtask

  task automatic test_abort();
    item_t got, want;
    bit ok;
    fill_test1();
    pulse_start();
    feed(NN + 5, 1'b0, -1, ok);
    rst = 1'b0;
    #1;
    n_vec++;
    if ({bus.in_ready, bus.out_valid, bus.out_sel, bus.out_idx, bus.out_data, busy, done} !== '0) begin
      n_err++;
      $display("FAIL t5_abort_outputs: got in_ready=%b out_valid=%b busy=%b done=%b data=%h, required all 0",
               bus.in_ready, bus.out_valid, busy, done, bus.out_data);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    push_expected();
    pulse_start();
    feed(2*NN, 1'b0, -1, ok);
    for (int e = 0; e < 2*N; e++) begin
      get_out(got, ok);
      n_vec++;
      if (!ok || exp_q.size() == 0) begin
        n_err++; $display("FAIL t5_out[%0d]: got no checksum (timeout=%0d), required one", e, !ok);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          n_err++;
          $display("FAIL t5_out[%0d]: got sel=%0d idx=%0d data=%h, required sel=%0d idx=%0d data=%h",
                   e, got.sel, got.idx, got.data, want.sel, want.idx, want.data);
        end
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_start_ignored();
    item_t got, want;
    bit ok;
    int a0, d0;
    for (int k = 0; k < NN; k++) begin
      mat_a[k] = DW'(k);
      mat_b[k] = DW'(255 - k);
    end
    push_expected();
    a0 = acc_cnt;
    d0 = done_cnt;
    pulse_start();
    feed(2*NN, 1'b0, 5, ok);
    for (int e = 0; e < 2*N; e++) begin
      get_out(got, ok);
      n_vec++;
      if (!ok || exp_q.size() == 0) begin
        n_err++; $display("FAIL t6_out[%0d]: got no checksum (timeout=%0d), required one", e, !ok);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          n_err++;
          $display("FAIL t6_out[%0d]: got sel=%0d idx=%0d data=%h, required sel=%0d idx=%0d data=%h",
                   e, got.sel, got.idx, got.data, want.sel, want.idx, want.data);
        end
      end
    end
    // Now in DONE: a start here must not launch another run.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if (busy !== 1'b0 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL t6_start_in_done: got busy=%b in_ready=%b out_valid=%b, required 0 0 0",
               busy, bus.in_ready, bus.out_valid);
    end
    n_vec++;
    if (acc_cnt - a0 != 2*NN || done_cnt - d0 != 1) begin
      n_err++;
      $display("FAIL t6_single_run: got accepts=%0d done_pulses=%0d, required %0d 1",
               acc_cnt - a0, done_cnt - d0, 2*NN);
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_gaps();
    test_abort();
    test_start_ignored();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
